// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit (8 ops) with zero/ones/parity flags and a beat counter.
// Optional accumulator operand path is compiled in with `define BITWISE_LOGIC_ACC_EN.
module bitwise_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;

  // Handshake: a beat moves on any rising edge where valid && ready; a producer holds
  // valid and its payload stable until accepted, and ready never depends on valid.
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] res;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = reset_n && (!s1_valid || s2_adv);
  assign in_fire  = in_valid && in_ready;

`ifdef BITWISE_LOGIC_ACC_EN
  logic             s1_acc;
  logic [WIDTH-1:0] acc;

  // The accumulator always holds the previous result, so a chained beat sees it in order.
  assign op_a = s1_acc ? acc : s1_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_acc <= 1'b0;
      acc    <= '0;
    end else begin
      if (in_fire) s1_acc <= in_acc;
      if (s1_adv)  acc    <= res;
    end
  end
`else
  logic unused_acc;

  assign unused_acc = in_acc;
  assign op_a       = s1_a;
`endif

  always_comb begin
    res = op_a;
    case (s1_op)
      OP_AND:  res = op_a & s1_b;
      OP_OR:   res = op_a | s1_b;
      OP_XOR:  res = op_a ^ s1_b;
      OP_NOR:  res = ~(op_a | s1_b);
      OP_NAND: res = ~(op_a & s1_b);
      OP_XNOR: res = ~(op_a ^ s1_b);
      OP_ANDN: res = op_a & ~s1_b;
      default: res = op_a;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_ones  <= 1'b0;
      out_par   <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (in_fire) begin
        s1_op <= in_op;
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
      if (in_fire)     s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      // A fresh load wins over a plain drain, so out_valid stays high through back-to-back beats.
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_zero  <= ~|res;
        out_ones  <= &res;
        out_par   <= ^res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed bench for bitwise_logic_pipe: reset, all ops, backpressure, counter wrap at WIDTH=1,
// accumulator chaining and reset mid-stream; results checked through an in-order expected queue.
`timescale 1ns/1ps
module tb_bitwise_logic_pipe;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // main instance (WIDTH=32, CNT_W=16)
  logic          in_valid, in_ready, in_acc, out_valid, out_ready;
  logic          out_zero, out_ones, out_par;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_data;
  logic [15:0]   beat_cnt;

  // narrow instance (WIDTH=1, CNT_W=4)
  logic          w_in_valid, w_in_ready, w_in_acc, w_out_valid, w_out_ready;
  logic          w_out_zero, w_out_ones, w_out_par;
  logic [2:0]    w_in_op;
  logic [0:0]    w_in_a, w_in_b, w_out_data;
  logic [3:0]    w_beat_cnt;

  bitwise_logic_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_acc(in_acc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_ones(out_ones), .out_par(out_par), .beat_cnt(beat_cnt)
  );

  bitwise_logic_pipe #(.WIDTH(1), .CNT_W(4)) u_dut_w1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op), .in_a(w_in_a), .in_b(w_in_b),
    .in_acc(w_in_acc), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_zero(w_out_zero), .out_ones(w_out_ones), .out_par(w_out_par), .beat_cnt(w_beat_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int accepted = 0;
  int last_wait = 0;
  int last_acc_cyc = 0;
  int first_acc = 0;
  int w_n = 0;
  logic [W-1:0] exp_q[$];
  int           hs_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] ops_exp [8];
  logic [W-1:0] exp2, exp3, exp_z;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic acc, input logic [W-1:0] exp);
    int waits = 0;
    bit got = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    check_eq("accept", 64'(got), 64'd1);
    last_wait = waits;
    if (got) begin
      exp_q.push_back(exp);
      last_acc_cyc = cyc;
      accepted++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      check_eq("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      check_eq("beat_cnt", 64'(beat_cnt), 64'(exp_cnt & 32'hFFFF));
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check_eq("out_data", 64'(out_data), 64'(mon_exp));
        check_eq("out_zero", 64'(out_zero), 64'(mon_exp == '0));
        check_eq("out_ones", 64'(out_ones), 64'(mon_exp == '1));
        check_eq("out_par", 64'(out_par), 64'(^mon_exp));
      end
      exp_cnt++;
      hs_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    ops_exp = '{32'h0000_0000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_0000,
                32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_A5A5, 32'h0000_A5A5};
    reset_n     = 1'b0;
    in_valid    = 1'b1;
    in_op       = 3'd0;
    in_a        = 32'h0000_A5A5;
    in_b        = 32'h0000_5A5A;
    in_acc      = 1'b0;
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_in_op     = 3'd0;
    w_in_a      = 1'b0;
    w_in_b      = 1'b0;
    w_in_acc    = 1'b0;
    w_out_ready = 1'b1;

    // reset held three cycles with a beat offered
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_data", 64'(out_data), 64'd0);
      check_eq("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    end
    check_eq("rst_flags", 64'({out_zero, out_ones, out_par}), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_eq("ready_after_rst", 64'(in_ready), 64'd1);

    // all eight ops back-to-back
    hs_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 32'h0000_A5A5, 32'h0000_5A5A, 1'b0, ops_exp[i]);
      if (i == 0) begin
        check_eq("first_accept_wait", 64'(last_wait), 64'd0);
        first_acc = last_acc_cyc;
      end
    end
    drain();
    check_eq("ops_hs_count", 64'(hs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < hs_q.size()) check_eq("ops_timing", 64'(hs_q[i]), 64'(first_acc + 2 + i));
    check_eq("ops_beat_cnt", 64'(beat_cnt), 64'd8);

    // backpressure: 4 beats while the sink stalls for 6 sampled cycles
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        send(3'd1, 32'h1111_0000, 32'h0000_FFFF, 1'b0, 32'h1111_FFFF);
        send(3'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 32'h0F00_0F00);
        send(3'd2, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'hEDCB_A987);
        send(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_hold_data", 64'(out_data), 64'h1111_FFFF);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
          end
        end
        check_eq("bp_accepted", 64'(accepted), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_beat_cnt", 64'(beat_cnt), 64'd12);

    // WIDTH=1 XOR 1^1, 17 handshakes through a 4-bit counter
    w_in_op    = 3'd2;
    w_in_a     = 1'b1;
    w_in_b     = 1'b1;
    w_in_valid = 1'b1;
    w_n        = 0;
    for (int i = 0; i < 100; i++) begin
      if (w_n >= 17) break;
      @(negedge clk);
      if (w_in_ready) w_n++;
    end
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    check_eq("w1_accepts", 64'(w_n), 64'd17);
    repeat (4) @(negedge clk);
    check_eq("w1_beat_cnt_wrap", 64'(w_beat_cnt), 64'd1);
    check_eq("w1_out_data", 64'(w_out_data), 64'd0);
    check_eq("w1_out_zero", 64'(w_out_zero), 64'd1);
    check_eq("w1_out_ones", 64'(w_out_ones), 64'd0);
    check_eq("w1_out_par", 64'(w_out_par), 64'd0);
    check_eq("w1_out_valid", 64'(w_out_valid), 64'd0);
    @(posedge clk);
    #1;

    // accumulator chaining (operand A replaced only when the feature is built in)
`ifdef BITWISE_LOGIC_ACC_EN
    exp2  = 32'hFFFF_FFF0;
    exp3  = 32'hFFFF_FFF0;
    exp_z = 32'h0000_0000;
`else
    exp2  = 32'hEDCB_A987;
    exp3  = 32'h1234_5678;
    exp_z = 32'h1234_5678;
`endif
    send(3'd1, 32'h0000_000F, 32'h0000_0000, 1'b0, 32'h0000_000F);
    send(3'd2, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, exp2);
    send(3'd7, 32'h1234_5678, 32'h0000_0000, 1'b1, exp3);
    drain();

    // reset with two beats in flight and the sink stalled
    out_ready = 1'b0;
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 32'h0000_FFFF);
    send(3'd1, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003);
    check_eq("mid_valid_before", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_in_ready", 64'(in_ready), 64'd0);
    check_eq("mid_out_data", 64'(out_data), 64'd0);
    check_eq("mid_beat_cnt", 64'(beat_cnt), 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(3'd7, 32'h1234_5678, 32'h0000_0000, 1'b1, exp_z);
    drain();
    check_eq("post_rst_beat_cnt", 64'(beat_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
